// File: rtl/axis_data_upsizer.sv
// AXI-Stream width upsizer: packs RATIO narrow beats into one wide beat, little-endian,
// with tlast closing a short word early and tkeep marking the filled lanes.
module axis_data_upsizer #(
  parameter int unsigned BUS_WIDTH = 2,
  parameter int unsigned RATIO     = 2
) (
  input  logic                           aclk,
  input  logic                           arst,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic [BUS_WIDTH*8-1:0]         s_axis_tdata,
  input  logic [BUS_WIDTH-1:0]           s_axis_tkeep,
  input  logic                           s_axis_tlast,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic [BUS_WIDTH*RATIO*8-1:0]   m_axis_tdata,
  output logic [BUS_WIDTH*RATIO-1:0]     m_axis_tkeep,
  output logic                           m_axis_tlast
);

  localparam int unsigned LANE_W = BUS_WIDTH * 8;
  localparam int unsigned DATA_W = LANE_W * RATIO;
  localparam int unsigned KEEP_W = BUS_WIDTH * RATIO;
  localparam int unsigned SLOT_W = $clog2(RATIO);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

  logic [SLOT_W-1:0] slot;
  logic              accept;
  logic              word_done;
  logic [DATA_W-1:0] data_nxt;
  logic [KEEP_W-1:0] keep_nxt;

  // Handshake decode and in-place lane merge; slot 0 starts a fresh, zeroed word.
  always_comb begin
    s_axis_tready = !arst && (!m_axis_tvalid || m_axis_tready);
    accept        = s_axis_tvalid && s_axis_tready;
    word_done     = accept && ((slot == LAST_SLOT) || s_axis_tlast);
    data_nxt      = (slot == '0) ? '0 : m_axis_tdata;
    keep_nxt      = (slot == '0) ? '0 : m_axis_tkeep;
    data_nxt[32'(slot) * LANE_W +: LANE_W]    = s_axis_tdata;
    keep_nxt[32'(slot) * BUS_WIDTH +: BUS_WIDTH] = s_axis_tkeep;
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      slot          <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        m_axis_tdata <= data_nxt;
        m_axis_tkeep <= keep_nxt;
        m_axis_tlast <= s_axis_tlast;
        if (word_done) begin
          slot          <= '0;
          m_axis_tvalid <= 1'b1;
        end else begin
          slot <= slot + SLOT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_data_upsizer.sv
// Directed bench for axis_data_upsizer: a RATIO=2 instance and a RATIO=4 instance,
// with hand-computed expected words.
module tb_axis_data_upsizer;

  logic aclk = 1'b0;
  logic arst;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // RATIO=2 instance
  logic        a_s_tvalid, a_s_tready, a_s_tlast;
  logic [15:0] a_s_tdata;
  logic [1:0]  a_s_tkeep;
  logic        a_m_tvalid, a_m_tready, a_m_tlast;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_m_tkeep;

  // RATIO=4 instance
  logic        b_s_tvalid, b_s_tready, b_s_tlast;
  logic [15:0] b_s_tdata;
  logic [1:0]  b_s_tkeep;
  logic        b_m_tvalid, b_m_tready, b_m_tlast;
  logic [63:0] b_m_tdata;
  logic [7:0]  b_m_tkeep;

  axis_data_upsizer #(.BUS_WIDTH(2), .RATIO(2)) dut_a (
    .aclk(aclk), .arst(arst),
    .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready), .s_axis_tdata(a_s_tdata),
    .s_axis_tkeep(a_s_tkeep), .s_axis_tlast(a_s_tlast),
    .m_axis_tvalid(a_m_tvalid), .m_axis_tready(a_m_tready), .m_axis_tdata(a_m_tdata),
    .m_axis_tkeep(a_m_tkeep), .m_axis_tlast(a_m_tlast)
  );

  axis_data_upsizer #(.BUS_WIDTH(2), .RATIO(4)) dut_b (
    .aclk(aclk), .arst(arst),
    .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready), .s_axis_tdata(b_s_tdata),
    .s_axis_tkeep(b_s_tkeep), .s_axis_tlast(b_s_tlast),
    .m_axis_tvalid(b_m_tvalid), .m_axis_tready(b_m_tready), .m_axis_tdata(b_m_tdata),
    .m_axis_tkeep(b_m_tkeep), .m_axis_tlast(b_m_tlast)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive_a(input logic [15:0] d, input logic [1:0] k, input logic l);
    a_s_tvalid = 1'b1;
    a_s_tdata  = d;
    a_s_tkeep  = k;
    a_s_tlast  = l;
  endtask

  task automatic drive_b(input logic [15:0] d, input logic [1:0] k, input logic l);
    b_s_tvalid = 1'b1;
    b_s_tdata  = d;
    b_s_tkeep  = k;
    b_s_tlast  = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    arst = 1'b1;
    a_s_tvalid = 1'b0; a_s_tdata = '0; a_s_tkeep = '0; a_s_tlast = 1'b0; a_m_tready = 1'b1;
    b_s_tvalid = 1'b0; b_s_tdata = '0; b_s_tkeep = '0; b_s_tlast = 1'b0; b_m_tready = 1'b1;
    tick();
    check("rst_valid", 64'(a_m_tvalid), 64'd0);
    check("rst_data",  64'(a_m_tdata),  64'd0);
    check("rst_keep",  64'(a_m_tkeep),  64'd0);
    check("rst_ready", 64'(a_s_tready), 64'd0);
    arst = 1'b0;
    tick();

    // Back-to-back packing, downstream always ready
    drive_a(16'h1111, 2'h3, 1'b0);
    check("t1_rdy0", 64'(a_s_tready), 64'd1);
    tick();
    drive_a(16'h2222, 2'h3, 1'b0);
    check("t1_rdy1", 64'(a_s_tready), 64'd1);
    tick();
    check("t1_w0_valid", 64'(a_m_tvalid), 64'd1);
    check("t1_w0_data",  64'(a_m_tdata),  64'h22221111);
    check("t1_w0_keep",  64'(a_m_tkeep),  64'hF);
    check("t1_w0_last",  64'(a_m_tlast),  64'd0);
    drive_a(16'h3333, 2'h3, 1'b0);
    check("t1_rdy2", 64'(a_s_tready), 64'd1);
    tick();
    check("t1_mid_valid", 64'(a_m_tvalid), 64'd0);
    drive_a(16'h4444, 2'h3, 1'b1);
    check("t1_rdy3", 64'(a_s_tready), 64'd1);
    tick();
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    check("t1_w1_valid", 64'(a_m_tvalid), 64'd1);
    check("t1_w1_data",  64'(a_m_tdata),  64'h44443333);
    check("t1_w1_keep",  64'(a_m_tkeep),  64'hF);
    check("t1_w1_last",  64'(a_m_tlast),  64'd1);
    tick();
    check("t1_drain", 64'(a_m_tvalid), 64'd0);

    // Single-beat word closed by tlast
    drive_a(16'hAAAA, 2'h3, 1'b1);
    tick();
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    check("t2_valid", 64'(a_m_tvalid), 64'd1);
    check("t2_data",  64'(a_m_tdata),  64'h0000AAAA);
    check("t2_keep",  64'(a_m_tkeep),  64'h3);
    check("t2_last",  64'(a_m_tlast),  64'd1);
    tick();
    check("t2_drain", 64'(a_m_tvalid), 64'd0);

    // Output stall holds everything, then release with a beat pending
    a_m_tready = 1'b0;
    drive_a(16'h1111, 2'h3, 1'b0);
    tick();
    drive_a(16'h2222, 2'h3, 1'b0);
    tick();
    drive_a(16'h5555, 2'h3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_rdy",   64'(a_s_tready), 64'd0);
      check("t3_stall_valid", 64'(a_m_tvalid), 64'd1);
      check("t3_stall_data",  64'(a_m_tdata),  64'h22221111);
      check("t3_stall_keep",  64'(a_m_tkeep),  64'hF);
      tick();
    end
    a_m_tready = 1'b1;
    #1;
    check("t3_release_rdy", 64'(a_s_tready), 64'd1);
    tick();
    check("t3_new_valid", 64'(a_m_tvalid), 64'd0);
    check("t3_new_data",  64'(a_m_tdata),  64'h00005555);
    check("t3_new_keep",  64'(a_m_tkeep),  64'h3);
    drive_a(16'h6666, 2'h3, 1'b0);
    tick();
    a_s_tvalid = 1'b0;
    check("t3_word_data", 64'(a_m_tdata), 64'h66665555);
    check("t3_word_keep", 64'(a_m_tkeep), 64'hF);
    tick();

    // Reset mid-word discards the partial word
    drive_a(16'h1234, 2'h3, 1'b0);
    tick();
    a_s_tvalid = 1'b0;
    arst = 1'b1;
    #1;
    check("t4_rst_valid", 64'(a_m_tvalid), 64'd0);
    check("t4_rst_keep",  64'(a_m_tkeep),  64'd0);
    check("t4_rst_rdy",   64'(a_s_tready), 64'd0);
    tick();
    arst = 1'b0;
    tick();
    drive_a(16'h5678, 2'h3, 1'b0);
    tick();
    drive_a(16'h9ABC, 2'h3, 1'b0);
    tick();
    a_s_tvalid = 1'b0;
    check("t4_valid", 64'(a_m_tvalid), 64'd1);
    check("t4_data",  64'(a_m_tdata),  64'h9ABC5678);
    check("t4_keep",  64'(a_m_tkeep),  64'hF);
    tick();

    // Partial keep on the last beat
    drive_a(16'hBEEF, 2'h3, 1'b0);
    tick();
    drive_a(16'h00CD, 2'h1, 1'b1);
    tick();
    a_s_tvalid = 1'b0; a_s_tlast = 1'b0;
    check("t5_data", 64'(a_m_tdata), 64'h00CDBEEF);
    check("t5_keep", 64'(a_m_tkeep), 64'h7);
    check("t5_last", 64'(a_m_tlast), 64'd1);
    tick();

    // RATIO=4: short word then full word
    drive_b(16'h0001, 2'h3, 1'b0);
    tick();
    drive_b(16'h0002, 2'h3, 1'b0);
    tick();
    drive_b(16'h0003, 2'h3, 1'b1);
    tick();
    b_s_tvalid = 1'b0; b_s_tlast = 1'b0;
    check("t6_short_valid", 64'(b_m_tvalid), 64'd1);
    check("t6_short_data",  b_m_tdata,       64'h0000000300020001);
    check("t6_short_keep",  64'(b_m_tkeep),  64'h3F);
    check("t6_short_last",  64'(b_m_tlast),  64'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_b(16'(16'hA + i), 2'h3, 1'b0);
      if (i < 3) begin
        tick();
        check("t6_fill_valid", 64'(b_m_tvalid), 64'd0);
      end else begin
        tick();
      end
    end
    b_s_tvalid = 1'b0;
    check("t6_full_valid", 64'(b_m_tvalid), 64'd1);
    check("t6_full_data",  b_m_tdata,       64'h000D000C000B000A);
    check("t6_full_keep",  64'(b_m_tkeep),  64'hFF);
    check("t6_full_last",  64'(b_m_tlast),  64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
